// File: rtl/datapath_pkg.sv
// rtl/datapath_pkg.sv - Shared opcode/state types and defaults for the sequenced datapath.
package datapath_pkg;

    localparam int DATA_W_DEF = 32;

    typedef enum logic [4:0] {
        OP_ADD  = 5'd0,
        OP_SUB  = 5'd1,
        OP_AND  = 5'd2,
        OP_OR   = 5'd3,
        OP_SHR  = 5'd4,
        OP_SHRA = 5'd5,
        OP_SHL  = 5'd6,
        OP_ROR  = 5'd7,
        OP_ROL  = 5'd8,
        OP_MUL  = 5'd9,
        OP_DIV  = 5'd10,
        OP_NEG  = 5'd11,
        OP_NOT  = 5'd12
    } opcode_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TA,
        S_TB,
        S_TLO,
        S_THI
    } seqState_t;

    // MUL/DIV produce a double-width result and take the extra THI step.
    function automatic logic isWideOp(input opcode_t op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/datapath_seq_alu_core.sv
// rtl/datapath_seq_alu_core.sv - Combinational ALU; result is {Zhi, Zlo}.
module alu_core
    import datapath_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    input  opcode_t             op,
    output logic [2*DATA_W-1:0] result
);
    localparam int SH_W = $clog2(DATA_W);
    localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    logic [SH_W-1:0]     shAmt;
    logic [DATA_W-1:0]   rorRes, rolRes, lowRes, highRes;
    logic [DATA_W-1:0]   quot, rem;
    logic [2*DATA_W-1:0] aExt, bExt, product;

    assign shAmt   = b[SH_W-1:0];
    assign rorRes  = DATA_W'({a, a} >> shAmt);
    assign rolRes  = DATA_W'(({a, a} << shAmt) >> DATA_W);
    assign aExt    = {{DATA_W{a[DATA_W-1]}}, a};
    assign bExt    = {{DATA_W{b[DATA_W-1]}}, b};
    assign product = $signed(aExt) * $signed(bExt);

    // Divide-by-zero and the one overflowing quotient are pinned explicitly.
    always_comb begin
        quot = '0;
        rem  = '0;
        if (b == '0) begin
            quot = '1;
            rem  = a;
        end else if ((a == MOST_NEG) && (b == '1)) begin
            quot = MOST_NEG;
            rem  = '0;
        end else begin
            quot = $signed(a) / $signed(b);
            rem  = $signed(a) % $signed(b);
        end
    end

    always_comb begin
        lowRes  = '0;
        highRes = '0;
        case (op)
            OP_ADD:  lowRes = a + b;
            OP_SUB:  lowRes = a - b;
            OP_AND:  lowRes = a & b;
            OP_OR:   lowRes = a | b;
            OP_SHR:  lowRes = a >> shAmt;
            OP_SHRA: lowRes = $signed(a) >>> shAmt;
            OP_SHL:  lowRes = a << shAmt;
            OP_ROR:  lowRes = rorRes;
            OP_ROL:  lowRes = rolRes;
            OP_MUL:  {highRes, lowRes} = product;
            OP_DIV: begin
                lowRes  = quot;
                highRes = rem;
            end
            OP_NEG:  lowRes = '0 - b;
            OP_NOT:  lowRes = ~b;
            default: ;
        endcase
    end

    assign result = {highRes, lowRes};

endmodule

// File: rtl/datapath_seq.sv
// rtl/datapath_seq.sv - Single-bus datapath with built-in ALU-instruction sequencer.
// DATAPATH_R0_ZERO_EN: register 0 is hard-wired to zero.
module datapath_seq
    import datapath_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = 16,
    parameter int SEL_W    = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic [4:0]        op,
    input  logic [SEL_W-1:0]  ra_sel,
    input  logic [SEL_W-1:0]  rb_sel,
    input  logic [SEL_W-1:0]  rd_sel,
    output logic              ready,
    output logic              done,
    input  logic              wr_en,
    input  logic [SEL_W-1:0]  wr_sel,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [SEL_W-1:0]  obs_sel,
    output logic [DATA_W-1:0] obs_data,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic [DATA_W-1:0] z_hi,
    output logic [DATA_W-1:0] z_lo,
    output logic [DATA_W-1:0] bus_dbg
);
`ifdef DATAPATH_R0_ZERO_EN
    localparam bit R0_ZERO = 1'b1;
`else
    localparam bit R0_ZERO = 1'b0;
`endif

    logic [DATA_W-1:0]   regFile [NUM_REGS];
    logic [DATA_W-1:0]   yReg, busVal;
    logic [2*DATA_W-1:0] aluResult;
    seqState_t           state;
    opcode_t             opReg;
    logic [SEL_W-1:0]    raReg, rbReg, rdReg;

    function automatic logic [DATA_W-1:0] regRead(input logic [SEL_W-1:0] idx);
        return (R0_ZERO && (idx == '0)) ? '0 : regFile[idx];
    endfunction

    always_comb begin
        busVal = '0;
        case (state)
            S_TA:    busVal = regRead(raReg);
            S_TB:    busVal = regRead(rbReg);
            S_TLO:   busVal = z_lo;
            S_THI:   busVal = z_hi;
            default: busVal = '0;
        endcase
    end

    assign bus_dbg  = busVal;
    assign obs_data = regRead(obs_sel);

    alu_core #(.DATA_W(DATA_W)) u_alu (
        .a      (yReg),
        .b      (busVal),
        .op     (opReg),
        .result (aluResult)
    );

    // done/ready are registered: each is set on the edge entering the cycle it describes.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= S_IDLE;
            opReg <= OP_ADD;
            raReg <= '0;
            rbReg <= '0;
            rdReg <= '0;
            yReg  <= '0;
            z_hi  <= '0;
            z_lo  <= '0;
            hi    <= '0;
            lo    <= '0;
            ready <= 1'b1;
            done  <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regFile[i] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (wr_en && !(R0_ZERO && (wr_sel == '0))) regFile[wr_sel] <= wr_data;
                    if (start) begin
                        opReg <= opcode_t'(op);
                        raReg <= ra_sel;
                        rbReg <= rb_sel;
                        rdReg <= rd_sel;
                        ready <= 1'b0;
                        state <= S_TA;
                    end
                end
                S_TA: begin
                    yReg  <= busVal;
                    state <= S_TB;
                end
                S_TB: begin
                    {z_hi, z_lo} <= aluResult;
                    done         <= !isWideOp(opReg);
                    state        <= S_TLO;
                end
                S_TLO: begin
                    if (isWideOp(opReg)) begin
                        lo    <= busVal;
                        done  <= 1'b1;
                        state <= S_THI;
                    end else begin
                        if (!(R0_ZERO && (rdReg == '0))) regFile[rdReg] <= busVal;
                        ready <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                S_THI: begin
                    hi    <= busVal;
                    ready <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/datapath_seq.md
# datapath_seq

Parametrised successor to the single-bus datapath. It keeps the register file, Y, Z, HI/LO and one shared internal bus, and adds a built-in micro-sequencer that runs a complete register-register ALU instruction from one start request. It sits between the future control unit and the ALU. It is also the unit-level harness for ALU-instruction timing.

## Interface
Parameters:
- DATA_W, 32, bus, register and ALU operand width; power of two, ≥8
- NUM_REGS, 16, general registers; power of two
- SEL_W, $clog2(NUM_REGS), register select width

Ports:
- clk  in  1  rising-edge clock
- clr  in  1  asynchronous, active-low reset
- start  in  1  request; accepted only when ready=1
- op  in  5  opcode (from shared package)
- ra_sel, rb_sel, rd_sel  in  SEL_W  source A, source B, destination
- ready  out  1  high in IDLE
- done  out  1  one-cycle pulse on the final sequence cycle
- wr_en  in  1  external register preload
- wr_sel  in  SEL_W  preload target
- wr_data  in  DATA_W  preload value
- obs_sel  in  SEL_W  observation select
- obs_data  out  DATA_W  combinational read of register[obs_sel]
- hi, lo  out  DATA_W  HI/LO registers
- z_hi, z_lo  out  DATA_W  Z register halves
- bus_dbg  out  DATA_W  current internal bus value; 0 when nothing drives it

## Operation
Opcodes:
- 0 ADD, 1 SUB, 2 AND, 3 OR
- 4 SHR (logical), 5 SHRA, 6 SHL, 7 ROR, 8 ROL; shift amount = B[$clog2(DATA_W)-1:0]
- 9 MUL (signed, 2·DATA_W result), 10 DIV (signed: Zlo = quotient, Zhi = remainder)
- 11 NEG B, 12 NOT B
- Reserved opcodes 13–31: Z = 0, Rd is written with 0.

Width rules:
- Single-width ops set Zhi = 0.
- ADD/SUB wrap modulo 2^DATA_W.
- DIV by zero: quotient all ones, remainder = A.
- DIV of most-negative by −1: quotient = most-negative, remainder = 0.

FSM states:
- IDLE: start accepted → TA. op and the selects are latched at acceptance.
- TA: bus = R[ra]; Y ← bus → TB.
- TB: bus = R[rb]; Z ← ALU(Y, bus) → TLO.
- TLO: bus = Zlo. Non-MUL/DIV: R[rd] ← bus, done = 1 → IDLE. MUL/DIV: LO ← bus → THI.
- THI: bus = Zhi; HI ← bus; done = 1 → IDLE.
- MUL/DIV never write Rd.

Preload and boundaries:
- wr_en is honoured only in IDLE and ignored otherwise.
- start and wr_en in the same IDLE cycle: the write lands at that edge, and TA reads the new value.
- ra = rb = rd is legal; Rd updates only at the end of TLO.
- start while busy is ignored, not queued.
- Reset asserted mid-sequence: FSM → IDLE; all registers, Y, Z, HI, LO → 0; no partial write completes.

## Timing
Reset values:
- obs_data, hi, lo, z_hi, z_lo, bus_dbg, done = 0; ready = 1.

Latency and throughput:
- Start accepted at edge N → done high in cycle N+3 (single-width) or N+4 (MUL/DIV).
- Rd, LO or HI holds its new value after the edge that ends the done cycle.
- ready is low from N+1 through the done cycle. It is high again in the cycle after done, so back-to-back throughput is one op per 4 (or 5) cycles.

Combinational paths:
- The ALU, including MUL and DIV, is purely combinational within TB.
- obs_data is combinational and sees writes one cycle after the writing edge.

## Configuration
Macro DATAPATH_R0_ZERO_EN:
- Defined: register 0 always reads 0. Sequence writes and wr_en to index 0 are discarded. obs_data for sel 0 is 0.
- Undefined: register 0 is an ordinary register.

## Structure
Shared package datapath_pkg holds:
- the opcode enum (5-bit) with the values above
- the FSM state enum
- the DATA_W default constant

One combinational sub-module, alu_core (A, B, op → 2·DATA_W result), holds all opcode arithmetic. datapath_seq holds the register file, Y, Z, HI/LO, the bus mux and the FSM.

## Test plan
- Preload R1=5, R2=7; ADD ra1 rb2 rd3 → done at N+3, R3=12, z_hi=0.
- Preload R4=−6, R5=4; MUL → done at N+4, LO=0xFFFFFFE8, HI=0xFFFFFFFF, R-file unchanged.
- R6=17, R7=0; DIV → LO=0xFFFFFFFF, HI=17; then R7=−5 → LO=0xFFFFFFFD, HI=2.
- R1=0x80000001, R2=1; ROL → 0x00000003; SHRA → 0xC0000000; start pulsed again during busy → ignored, exactly one done.
- Reset pulsed during TB of ADD into R3 (R3 preloaded to 9) → after release, R3=0, ready=1, done never pulsed.
- With DATAPATH_R0_ZERO_EN: ADD rd0 → obs_data(0)=0; wr_en to R0 with 0x1234 → still 0. Without the macro: 0x1234 is stored.
